mul_tree_with_regs: RTL and testbench
=====================================

MUL_TREE_WITH_REGS -- requirements
Module: mul_tree_with_regs

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits and product width at 64 bits.
REQ-002 The port order SHALL be a, b, clk, reset, en, result, overflow, so that positional instantiation works.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  register enable; high = pipeline advances, low = all registers hold.
REQ-006 a  input  32  multiplicand, signed two's complement.
REQ-007 b  input  32  multiplier, signed two's complement.
REQ-008 result  output  64  signed product a*b, registered.
REQ-009 overflow  output  1  registered flag; set when the product does not fit in a signed 32-bit value.

Function
REQ-010 Stage 1 SHALL register a and b into internal registers ra and rb on a rising clk edge when en=1 and reset=0.
REQ-011 Stage 2 SHALL compute the product of ra and rb combinationally.
  - Partial products are generated as signed (Baugh-Wooley or sign-extended) rows.
  - Rows are reduced by a tree of carry-save adders (Wallace or Dadda) down to two rows.
  - A final 64-bit carry-propagate adder sums the last two rows.
REQ-012 The combinational result SHALL equal the exact signed 64-bit product for all 2^64 operand pairs, including -2^31 * -2^31 = 2^62.
REQ-013 result and overflow SHALL be registered on the rising clk edge when en=1 and reset=0.
REQ-014 Latency SHALL be 2 clock edges: operands sampled at edge N appear on result after edge N+1. Throughput is one operation per cycle.
REQ-015 overflow SHALL be 1 exactly when the product is outside the range [-2^31, 2^31-1]; otherwise it SHALL be 0.
REQ-016 When en=0 and reset=0, ra, rb, result and overflow SHALL all hold their values.
REQ-017 result SHALL not depend combinationally on a, b or en; it depends only on registered state.
REQ-018 The block SHALL contain no behavioural multiply operator; the product SHALL come from the explicit partial-product tree.

Reset
REQ-019 When reset=1 at a rising clk edge, ra, rb, result and overflow SHALL become 0, regardless of en.
REQ-020 Reset SHALL have priority over en and over new operands.
REQ-021 An operation that is in flight when reset asserts SHALL be discarded.
REQ-022 After reset is released, result SHALL remain 0 until the first new operands have propagated through both stages (2 edges).

Verification
REQ-023 Reset held for 2 edges -> result=0, overflow=0.
REQ-024 Sign cases, en=1, each checked 2 edges after apply:
  - a=5, b=-7 -> -35
  - a=2, b=3 -> 6
  - a=-12, b=-4 -> 48
  - a=-9, b=5 -> -45
  - a=11, b=0 -> 0
  - a=10, b=1 -> 10
  - a=4, b=6 -> 24
  - a=-1, b=-7 -> 7
  All with overflow=0.
REQ-025 Extremes:
  - a=-2147483648, b=-2147483648 -> result=4611686018427387904, overflow=1
  - a=65536, b=65536 -> result=4294967296, overflow=1
  - a=-2147483648, b=1 -> result=-2147483648, overflow=0
REQ-026 Back-to-back operand pairs applied on consecutive edges -> each product appears exactly 2 edges after its own operands, one per cycle, in order.
REQ-027 Hold: compute 5*-7, then drop en and change a=3, b=3 -> result stays -35; raise en -> 9 appears 2 edges later.
REQ-028 Reset mid-operation: apply a=-9, b=5, then assert reset on the next edge -> result=0 and -45 never appears.

Source files
------------

// File: rtl/mul_tree_with_regs.sv
// mul_tree_with_regs
//   Two-stage signed 32x32 -> 64 multiplier built from an explicit
//   partial-product array and a carry-save (Wallace-style) reduction tree.
//
//   Stage 1: a, b captured into ra, rb.
//   Stage 2: ra*rb formed combinationally from the tree, then registered
//            into result together with the 32-bit overflow flag.
//
//   Ports
//     a        in  32  multiplicand, signed two's complement
//     b        in  32  multiplier, signed two's complement
//     clk      in   1  clock, rising edge
//     reset    in   1  synchronous active-high reset (clears all registers)
//     en       in   1  advance enable; low holds every register
//     result   out 64  registered signed product
//     overflow out  1  registered flag: product outside [-2^31, 2^31-1]
//
//   There is no handshake: every enabled edge accepts one operand pair
//   and retires the pair accepted on the previous enabled edge.
module mul_tree_with_regs (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [63:0] result,
    output logic        overflow
);

    localparam int ROWS = 33;   // 32 partial products + negation carry-in

    logic [31:0] ra;
    logic [31:0] rb;

    logic [63:0] pp      [ROWS];
    logic [63:0] work    [ROWS];
    logic [63:0] nxt     [ROWS];
    logic [63:0] a_ext;
    logic [63:0] prod;
    logic        prod_ovf;
    int          n_rows;
    int          m_rows;

    // ------------------------------------------------------------------
    // Partial products. Multiplicand is sign-extended to 64 bits. Bit 31
    // of the multiplier carries weight -2^31, so its row is the two's
    // complement negation of the shifted multiplicand: the inverted row
    // here plus a single 1 injected in the extra row at bit 0.
    // ------------------------------------------------------------------
    always_comb begin
        a_ext = {{32{ra[31]}}, ra};
        for (int i = 0; i < 31; i++) begin
            pp[i] = rb[i] ? (a_ext << i) : 64'd0;
        end
        pp[31] = rb[31] ? ~(a_ext << 31) : 64'd0;
        pp[32] = {63'd0, rb[31]};
    end

    // ------------------------------------------------------------------
    // Carry-save reduction. Each level groups rows in threes and replaces
    // each group by a sum row and a left-shifted carry row; leftover rows
    // pass through. Row counts: 33 22 15 10 7 5 4 3 2 -> eight levels.
    // Carries out of bit 63 are dropped: the tree works modulo 2^64,
    // which is exact for a 64-bit signed product.
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            work[r] = pp[r];
            nxt[r]  = 64'd0;
        end
        n_rows = ROWS;
        m_rows = 0;
        for (int lvl = 0; lvl < 8; lvl++) begin
            for (int r = 0; r < ROWS; r++) begin
                nxt[r] = 64'd0;
            end
            m_rows = 0;
            for (int g = 0; g < ROWS / 3; g++) begin
                if (3 * g + 2 < n_rows) begin
                    nxt[m_rows]     = work[3*g] ^ work[3*g+1] ^ work[3*g+2];
                    nxt[m_rows + 1] = ((work[3*g]   & work[3*g+1]) |
                                       (work[3*g]   & work[3*g+2]) |
                                       (work[3*g+1] & work[3*g+2])) << 1;
                    m_rows = m_rows + 2;
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                if ((r >= (n_rows / 3) * 3) && (r < n_rows)) begin
                    nxt[m_rows] = work[r];
                    m_rows = m_rows + 1;
                end
            end
            n_rows = m_rows;
            for (int r = 0; r < ROWS; r++) begin
                work[r] = nxt[r];
            end
        end
        // Final carry-propagate adder over the last two rows.
        prod = work[0] + work[1];
        // Fits in signed 32 bits only when bits 63..31 are all equal.
        prod_ovf = !((&prod[63:31]) || !(|prod[63:31]));
    end

    // ------------------------------------------------------------------
    // Pipeline registers. Reset wins over en; en low freezes both stages.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ra       <= 32'd0;
            rb       <= 32'd0;
            result   <= 64'd0;
            overflow <= 1'b0;
        end else if (en) begin
            ra       <= a;
            rb       <= b;
            result   <= prod;
            overflow <= prod_ovf;
        end
    end

endmodule

// File: tb/tb_mul_tree_with_regs.sv
module tb_mul_tree_with_regs;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] result;
    logic        overflow;

    always #5 clk = ~clk;

    mul_tree_with_regs dut (
        .a        (a),
        .b        (b),
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .result   (result),
        .overflow (overflow)
    );

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] r;
        logic        ov;
    } vec_t;

    vec_t vecs [11];

    // scoreboard: operand pairs accepted on enabled edges, oldest first
    logic [63:0] exp_q [$];

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    function automatic logic ref_ovf(input logic [63:0] p);
        longint sp;
        sp = $signed(p);
        return (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic chk_out(input string name, input logic [63:0] req_r, input logic req_o);
        chk({name, ".result"}, result, req_r);
        chk({name, ".overflow"}, {63'd0, overflow}, {63'd0, req_o});
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
    endtask

    task automatic apply(input logic [31:0] x, input logic [31:0] y);
        a = x;
        b = y;
        en = 1'b1;
        tick();
        tick();
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0]  = '{32'sd5,    -32'sd7, -64'sd35, 1'b0};
        vecs[1]  = '{32'sd2,     32'sd3,  64'sd6,  1'b0};
        vecs[2]  = '{-32'sd12,  -32'sd4,  64'sd48, 1'b0};
        vecs[3]  = '{-32'sd9,    32'sd5, -64'sd45, 1'b0};
        vecs[4]  = '{32'sd11,    32'sd0,  64'sd0,  1'b0};
        vecs[5]  = '{32'sd10,    32'sd1,  64'sd10, 1'b0};
        vecs[6]  = '{32'sd4,     32'sd6,  64'sd24, 1'b0};
        vecs[7]  = '{-32'sd1,   -32'sd7,  64'sd7,  1'b0};
        vecs[8]  = '{32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b1};
        vecs[9]  = '{32'd65536,  32'd65536, 64'h0000000100000000, 1'b1};
        vecs[10] = '{32'h80000000, 32'd1, 64'hFFFFFFFF80000000, 1'b0};

        a = 32'd0;
        b = 32'd0;
        en = 1'b0;
        reset = 1'b1;

        // reset held for two edges, en low
        do_reset(2);
        chk_out("reset", 64'd0, 1'b0);

        // table-driven directed vectors
        for (int i = 0; i < 11; i++) begin
            apply(vecs[i].a, vecs[i].b);
            chk_out($sformatf("vec%0d", i), vecs[i].r, vecs[i].ov);
        end

        // hold: 5*-7, drop en, change operands, result must not move
        apply(32'sd5, -32'sd7);
        en = 1'b0;
        a = 32'd3;
        b = 32'd3;
        tick();
        chk_out("hold1", -64'sd35, 1'b0);
        tick();
        tick();
        chk_out("hold3", -64'sd35, 1'b0);
        en = 1'b1;
        tick();
        chk_out("hold_resume1", -64'sd35, 1'b0);
        tick();
        chk_out("hold_resume2", 64'd9, 1'b0);

        // reset mid-operation: -9*5 in stage 1 is discarded
        a = -32'sd9;
        b = 32'sd5;
        en = 1'b1;
        tick();
        reset = 1'b1;
        a = 32'd0;
        b = 32'd0;
        tick();
        chk_out("midreset", 64'd0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("midreset_after%0d", i), 64'd0, 1'b0);
        end

        // reset priority over en with fresh operands, then latency after release
        apply(32'sd7, 32'sd7);
        a = 32'sd100;
        b = 32'sd100;
        reset = 1'b1;
        tick();
        chk_out("reset_prio", 64'd0, 1'b0);
        reset = 1'b0;
        a = 32'sd3;
        b = -32'sd2;
        tick();
        chk_out("post_reset_edge1", 64'd0, 1'b0);
        tick();
        chk_out("post_reset_edge2", -64'sd6, 1'b0);

        // back-to-back random pairs with en always high
        do_reset(1);
        exp_q.delete();
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 7 == 0) a = 32'h80000000;
            if (i % 11 == 0) b = 32'(-int'($urandom_range(0, 50000)));
            exp_q.push_back(ref_prod(a, b));
            tick();
            void'(exp_q.pop_front());
            chk($sformatf("b2b%0d.result", i), result, exp_q[0]);
            chk($sformatf("b2b%0d.overflow", i), {63'd0, overflow}, {63'd0, ref_ovf(exp_q[0])});
        end

        // random operands with random en; result is the product of the
        // second-most-recent accepted pair
        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = 32'(int'($urandom_range(0, 200)) - 100);
                         b = 32'(int'($urandom_range(0, 200)) - 100); end
                default: begin a = 32'(int'($urandom_range(0, 131072)) - 65536);
                               b = 32'(int'($urandom_range(0, 131072)) - 65536); end
            endcase
            if (en) begin
                exp_q.push_back(ref_prod(a, b));
                void'(exp_q.pop_front());
            end
            tick();
            chk($sformatf("rnd%0d.result", i), result, exp_q[0]);
            chk($sformatf("rnd%0d.overflow", i), {63'd0, overflow}, {63'd0, ref_ovf(exp_q[0])});
        end

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1);
    end

endmodule
